shift_rows_pipe: RTL and testbench

//  Pipelined, parametrised Rijndael ShiftRows/InvShiftRows unit for the AES datapath.
//  Per-beat mode selects forward (encrypt) or inverse (decrypt) row rotation.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/shift_rows_pipe_if.sv | 27 ++
 rtl/shift_rows_comb.sv | 22 ++
 rtl/shift_rows_pipe.sv | 75 +++++++
 tb/tb_shift_rows_pipe.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared Rijndael helpers: legal block widths, ShiftRows row offsets and the
// byte position of (row, column) within a packed state.
package aes_pkg;

    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Rows 2 and 3 move one step further for 256-bit blocks.
    function automatic int shift_off(input int nb, input int r);
        if (r == 0)
            return 0;
        else if ((nb == 8) && (r >= 2))
            return r + 1;
        else
            return r;
    endfunction

    function automatic int byte_idx(input int r, input int c);
        return 4 * c + r;
    endfunction

endpackage

// File: rtl/shift_rows_pipe_if.sv
// Beat interface for the ShiftRows pipe: input handshake with mode/tag/state,
// output handshake with rotated state/tag, plus the buffer occupancy.
interface shift_rows_pipe_if #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic              in_inv;
    logic [TAG_W-1:0]  in_tag;
    logic [32*NB-1:0]  in_state;
    logic              out_valid;
    logic              out_ready;
    logic [32*NB-1:0]  out_state;
    logic [TAG_W-1:0]  out_tag;
    logic [1:0]        occupancy;

    modport slave (
        input  in_valid, in_inv, in_tag, in_state, out_ready,
        output in_ready, out_valid, out_state, out_tag, occupancy
    );

    modport master (
        output in_valid, in_inv, in_tag, in_state, out_ready,
        input  in_ready, out_valid, out_state, out_tag, occupancy
    );
endinterface

// File: rtl/shift_rows_comb.sv
// Pure combinational ShiftRows / InvShiftRows byte permutation for NB columns.
module shift_rows_comb
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic             inv,
    input  logic [32*NB-1:0] din,
    output logic [32*NB-1:0] dout
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int OFF = shift_off(NB, r);
            localparam int FC  = (c + OFF) % NB;
            localparam int IC  = (c + NB - OFF) % NB;
            assign dout[8*byte_idx(r, c) +: 8] = inv ? din[8*byte_idx(r, IC) +: 8]
                                                     : din[8*byte_idx(r, FC) +: 8];
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// ShiftRows/InvShiftRows stage with a 2-entry output buffer; in_ready depends
// only on the registered count so out_ready never reaches in_ready combinationally.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    shift_rows_pipe_if.slave  bus
);

    localparam int W = 32 * NB;

    if (!nb_legal(NB)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    logic [W-1:0]     xf_state;
    logic [W-1:0]     mem_state [2];
    logic [TAG_W-1:0] mem_tag   [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    shift_rows_comb #(.NB(NB)) u_comb (
        .inv  (bus.in_inv),
        .din  (bus.in_state),
        .dout (xf_state)
    );

    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.occupancy = count;
    assign bus.out_state = mem_state[rd_ptr];
    assign bus.out_tag   = mem_tag[rd_ptr];

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_state[0] <= '0;
            mem_state[1] <= '0;
            mem_tag[0]   <= '0;
            mem_tag[1]   <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
        end else if (flush) begin
            // Storage is left as is; only the pointers and count matter once empty.
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem_state[wr_ptr] <= xf_state;
                mem_tag[wr_ptr]   <= bus.in_tag;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe at NB=4 (handshake, buffer, flush, reset)
// and NB=8 (offset table spot checks).
module tb_shift_rows_pipe;
    import aes_pkg::*;

    localparam logic [127:0] S4   = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] FWD4 = 128'h0b06010c07020d08030e09040f0a0500;
    localparam logic [127:0] INV4 = 128'h0306090c0f0205080b0e0104070a0d00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] s8;
    logic [255:0] o8;

    shift_rows_pipe_if #(.NB(4), .TAG_W(4)) b4 ();
    shift_rows_pipe_if #(.NB(8), .TAG_W(4)) b8 ();

    shift_rows_pipe #(.NB(4), .TAG_W(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (b4)
    );

    shift_rows_pipe #(.NB(8), .TAG_W(4)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (b8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic v, input logic inv, input logic [3:0] tag,
                          input logic [127:0] st);
        b4.in_valid = v;
        b4.in_inv   = inv;
        b4.in_tag   = tag;
        b4.in_state = st;
    endtask

    initial begin
        drive4(1'b0, 1'b0, 4'd0, '0);
        b4.out_ready = 1'b1;
        b8.in_valid  = 1'b0;
        b8.in_inv    = 1'b0;
        b8.in_tag    = 4'd0;
        b8.in_state  = '0;
        b8.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) s8[8*i +: 8] = 8'(i);

        // reset state
        #12;
        chk("rst_occ",      256'(b4.occupancy), 256'd0);
        chk("rst_out_valid", 256'(b4.out_valid), 256'd0);
        chk("rst_out_state", 256'(b4.out_state), 256'd0);
        chk("rst_out_tag",   256'(b4.out_tag),   256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 256'(b4.in_ready), 256'd1);

        // forward, then inverse of the result back-to-back, then inverse of the original
        drive4(1'b1, 1'b0, 4'd3, S4);
        step();
        chk("fwd_valid", 256'(b4.out_valid), 256'd1);
        chk("fwd_state", 256'(b4.out_state), 256'(FWD4));
        chk("fwd_tag",   256'(b4.out_tag),   256'd3);
        drive4(1'b1, 1'b1, 4'd4, FWD4);
        step();
        chk("roundtrip_occ",   256'(b4.occupancy), 256'd1);
        chk("roundtrip_state", 256'(b4.out_state), 256'(S4));
        chk("roundtrip_tag",   256'(b4.out_tag),   256'd4);
        drive4(1'b1, 1'b1, 4'd5, S4);
        step();
        chk("inv_state", 256'(b4.out_state), 256'(INV4));
        chk("inv_tag",   256'(b4.out_tag),   256'd5);
        drive4(1'b0, 1'b0, 4'd0, '0);
        step();
        chk("drain_valid", 256'(b4.out_valid), 256'd0);

        // backpressure: three beats offered, two taken, head stable
        b4.out_ready = 1'b0;
        drive4(1'b1, 1'b0, 4'd1, S4);
        step();
        drive4(1'b1, 1'b1, 4'd2, S4);
        step();
        chk("bp_occ2",    256'(b4.occupancy), 256'd2);
        chk("bp_in_ready", 256'(b4.in_ready), 256'd0);
        drive4(1'b1, 1'b0, 4'd7, 128'hdeadbeef);
        step();
        step();
        chk("bp_occ_hold",  256'(b4.occupancy), 256'd2);
        chk("bp_head_tag",  256'(b4.out_tag),   256'd1);
        chk("bp_head_state", 256'(b4.out_state), 256'(FWD4));
        drive4(1'b0, 1'b0, 4'd0, '0);
        b4.out_ready = 1'b1;
        step();
        chk("bp_pop1_occ",   256'(b4.occupancy), 256'd1);
        chk("bp_pop1_tag",   256'(b4.out_tag),   256'd2);
        chk("bp_pop1_state", 256'(b4.out_state), 256'(INV4));
        step();
        chk("bp_empty_occ", 256'(b4.occupancy), 256'd0);

        // flush with a same-cycle push
        b4.out_ready = 1'b0;
        drive4(1'b1, 1'b0, 4'd6, S4);
        step();
        step();
        chk("fl_pre_occ", 256'(b4.occupancy), 256'd2);
        flush = 1'b1;
        b4.in_valid = 1'b1;
        step();
        flush = 1'b0;
        drive4(1'b0, 1'b0, 4'd0, '0);
        chk("fl_occ",       256'(b4.occupancy), 256'd0);
        chk("fl_out_valid", 256'(b4.out_valid), 256'd0);
        chk("fl_in_ready",  256'(b4.in_ready),  256'd1);

        // asynchronous reset mid-stream
        drive4(1'b1, 1'b0, 4'd9, S4);
        step();
        drive4(1'b0, 1'b0, 4'd0, '0);
        chk("ar_pre_occ", 256'(b4.occupancy), 256'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_occ",       256'(b4.occupancy), 256'd0);
        chk("ar_out_valid", 256'(b4.out_valid), 256'd0);
        chk("ar_out_state", 256'(b4.out_state), 256'd0);
        chk("ar_out_tag",   256'(b4.out_tag),   256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        b4.out_ready = 1'b1;
        step();

        // NB=8 forward: offsets {0,1,3,4}
        b8.in_valid = 1'b1;
        b8.in_inv   = 1'b0;
        b8.in_tag   = 4'd8;
        b8.in_state = s8;
        step();
        b8.in_valid = 1'b0;
        o8 = b8.out_state;
        chk("nb8_valid", 256'(b8.out_valid), 256'd1);
        chk("nb8_f_r2c0", 256'(o8[8*2 +: 8]),  256'd14);
        chk("nb8_f_r3c7", 256'(o8[8*31 +: 8]), 256'd15);
        chk("nb8_f_r1c7", 256'(o8[8*29 +: 8]), 256'd1);
        chk("nb8_f_r0c5", 256'(o8[8*20 +: 8]), 256'd20);
        chk("nb8_tag",    256'(b8.out_tag),    256'd8);

        // NB=8 inverse
        b8.in_valid = 1'b1;
        b8.in_inv   = 1'b1;
        step();
        b8.in_valid = 1'b0;
        o8 = b8.out_state;
        chk("nb8_i_r3c0", 256'(o8[8*3 +: 8]), 256'd19);
        chk("nb8_i_r2c1", 256'(o8[8*6 +: 8]), 256'd26);
        chk("nb8_i_r1c0", 256'(o8[8*1 +: 8]), 256'd29);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
